// File: rtl/vh_result_unpacker_pkg.sv
// Shared types and field-layout helpers for the vloghammer result unpacker.
// A packed word is NGROUPS groups of six fields; field 0 sits at the word MSB.
package vh_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Field widths cycle 4,5,6 bits.
  function automatic int FIELD_W(input int i);
    return 4 + (i % 3);
  endfunction

  // Each group of six is three unsigned fields followed by three signed fields.
  function automatic bit FIELD_SIGNED(input int i);
    return ((i / 3) % 2) == 1;
  endfunction

  // Bit offset of field i measured down from the word MSB; a triple spans 15 bits.
  function automatic int FIELD_OFS(input int i);
    int sub;
    sub = i % 3;
    return (i / 3) * 15 + ((sub == 0) ? 0 : ((sub == 1) ? 4 : 9));
  endfunction

endpackage

// File: rtl/vh_field_extend.sv
// Combinational field selector: picks field idx out of the held word and
// zero- or sign-extends it to OUT_W bits, reporting whether it is signed.
module vh_field_extend
  import vh_pkg::*;
#(
  parameter int IN_W    = 90,
  parameter int NFIELDS = 18,
  parameter int IW      = 5,
  parameter int OUT_W   = 8
) (
  input  logic [IN_W-1:0]  word,
  input  logic [IW-1:0]    idx,
  output logic [OUT_W-1:0] value,
  output logic             is_signed
);

  logic [OUT_W-1:0] ext [NFIELDS];

  for (genvar g = 0; g < NFIELDS; g++) begin : g_field
    localparam int W   = FIELD_W(g);
    localparam int OFS = FIELD_OFS(g);
    logic [W-1:0] f;
    assign f = word[IN_W-1-OFS -: W];
    if (FIELD_SIGNED(g)) begin : g_sx
      assign ext[g] = OUT_W'($signed(f));
    end else begin : g_zx
      assign ext[g] = OUT_W'(f);
    end
  end

  // Select the extended value for the current index; out-of-range reads as zero.
  always_comb begin
    value     = '0;
    is_signed = 1'b0;
    for (int i = 0; i < NFIELDS; i++) begin
      if (idx == IW'(i)) begin
        value     = ext[i];
        is_signed = FIELD_SIGNED(i);
      end
    end
  end

endmodule

// File: rtl/vh_result_unpacker.sv
// Receive-side unpacker for the vloghammer packed result bus.
// Takes one packed word per in_valid/in_ready handshake and emits its fields
// one per out_valid/out_ready handshake, MSB field first.
// Handshakes: a transfer happens on a rising edge where valid && ready; a
// producer holds valid and its payload stable until that edge.
// Optional feature macro: VH_UNPACK_SIGNATURE_EN (running 32-bit signature on sig).
module vh_result_unpacker
  import vh_pkg::*;
#(
  parameter  int NGROUPS = 3,
  parameter  int OUT_W   = 8,
  localparam int IN_W    = 30 * NGROUPS,
  localparam int NFIELDS = 6 * NGROUPS,
  localparam int IW      = $clog2(NFIELDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_idx,
  output logic [OUT_W-1:0] out_data,
  output logic             out_signed,
  output logic             out_last,
  output logic [31:0]      sig
);

  state_t           state, state_n;
  logic [IN_W-1:0]  hold;
  logic [IW-1:0]    idx;
  logic             load, adv;
  logic             emit, at_last;
  logic [OUT_W-1:0] ext_value;
  logic             ext_signed;

  assign emit    = (state == EMIT);
  assign at_last = (idx == IW'(NFIELDS - 1));

  vh_field_extend #(
    .IN_W   (IN_W),
    .NFIELDS(NFIELDS),
    .IW     (IW),
    .OUT_W  (OUT_W)
  ) u_extend (
    .word     (hold),
    .idx      (idx),
    .value    (ext_value),
    .is_signed(ext_signed)
  );

  // Outputs are forced to zero outside EMIT so reset and idle look identical.
  assign out_valid  = emit;
  assign out_last   = emit && at_last;
  assign out_idx    = emit ? idx : '0;
  assign out_data   = emit ? ext_value : '0;
  assign out_signed = emit && ext_signed;
  assign in_ready   = !emit || (at_last && out_ready);

  // State register, hold register and field index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        hold <= in_data;
        idx  <= '0;
      end else if (adv) begin
        idx <= idx + IW'(1);
      end
    end
  end

  // Next-state logic: a new word may be captured on the same edge the last field leaves.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (at_last) begin
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef VH_UNPACK_SIGNATURE_EN
  logic [31:0] sig_q;

  // Rotate-and-xor signature over every accepted field; survives word boundaries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else if (out_valid && out_ready) begin
      sig_q <= {sig_q[30:0], sig_q[31]} ^ 32'(out_data);
    end
  end

  assign sig = sig_q;
`else
  assign sig = 32'h0;
`endif

endmodule

// File: tb/tb_vh_result_unpacker.sv
// Directed bench for vh_result_unpacker (NGROUPS=3, OUT_W=8).
module tb_vh_result_unpacker;

  localparam int IN_W    = 90;
  localparam int NFIELDS = 18;
  localparam int IW      = 5;
  localparam int OUT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    out_idx;
  logic [OUT_W-1:0] out_data;
  logic             out_signed;
  logic             out_last;
  logic [31:0]      sig;

  int errors = 0;
  int checks = 0;
  logic [OUT_W-1:0] exp_q[$];

  vh_result_unpacker #(
    .NGROUPS(3),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_signed(out_signed),
    .out_last  (out_last),
    .sig       (sig)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived value of each field of an all-ones word.
  function automatic logic [OUT_W-1:0] ones_val(input int i);
    case (i % 6)
      0:       return 8'h0F;
      1:       return 8'h1F;
      2:       return 8'h3F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic exp_signed(input int i);
    return ((i / 3) % 2) == 1;
  endfunction

  task automatic accept(input logic [IN_W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    #1;
    chk("accept_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
  endtask

  // Consume fields idx 0..stop_at-1, optionally stalling stall_n cycles at stall_at.
  task automatic drain(input int stall_at, input int stall_n, input int stop_at);
    logic [OUT_W-1:0] e;
    for (int i = 0; i < stop_at; i++) begin
      e = exp_q.pop_front();
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          out_ready = 1'b0;
          #1;
          chk("stall_valid", 32'(out_valid), 32'h1);
          chk("stall_idx",   32'(out_idx),   32'(i));
          chk("stall_data",  32'(out_data),  32'(e));
          chk("stall_ready", 32'(in_ready),  32'h0);
          step();
        end
      end
      out_ready = 1'b1;
      #1;
      chk("field_valid",  32'(out_valid),  32'h1);
      chk("field_idx",    32'(out_idx),    32'(i));
      chk("field_data",   32'(out_data),   32'(e));
      chk("field_signed", 32'(out_signed), 32'(exp_signed(i)));
      chk("field_last",   32'(out_last),   32'(i == NFIELDS - 1));
      chk("field_in_rdy", 32'(in_ready),   32'(i == NFIELDS - 1));
      step();
    end
  endtask

  initial begin
    logic [OUT_W-1:0] e;
    logic [31:0]      exp_sig;

    // reset
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid",  32'(out_valid),  32'h0);
    chk("rst_in_ready",   32'(in_ready),   32'h1);
    chk("rst_out_idx",    32'(out_idx),    32'h0);
    chk("rst_out_data",   32'(out_data),   32'h0);
    chk("rst_out_signed", 32'(out_signed), 32'h0);
    chk("rst_out_last",   32'(out_last),   32'h0);
    chk("rst_sig",        sig,             32'h0);
    rst_n = 1'b1;
    step();

    // 1: all-zero word
    for (int i = 0; i < NFIELDS; i++) exp_q.push_back(8'h00);
    accept('0);
    drain(-1, 0, NFIELDS);
    #1;
    chk("zero_idle_valid", 32'(out_valid), 32'h0);
    step();

    // 2: all-ones word
    for (int i = 0; i < NFIELDS; i++) exp_q.push_back(ones_val(i));
    accept('1);
    drain(-1, 0, NFIELDS);
    step();

    // 3: only field 3 (bits [74:71]) = 4'b1000
    for (int i = 0; i < NFIELDS; i++) exp_q.push_back((i == 3) ? 8'hF8 : 8'h00);
    accept(90'h8 << 71);
    drain(-1, 0, NFIELDS);
    step();

    // 4: backpressure for 5 cycles at idx 7
    for (int i = 0; i < NFIELDS; i++) exp_q.push_back(ones_val(i));
    accept('1);
    drain(7, 5, NFIELDS);
    #1;
    chk("bp_idle_valid", 32'(out_valid), 32'h0);
    step();

    // 5: back-to-back zeros word then ones word, in_valid held
    in_valid = 1'b1;
    in_data  = '0;
    #1;
    chk("b2b_first_ready", 32'(in_ready), 32'h1);
    step();
    in_data   = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 2 * NFIELDS; c++) begin
      in_valid = (c <= NFIELDS - 1);
      e = (c < NFIELDS) ? 8'h00 : ones_val(c - NFIELDS);
      #1;
      chk("b2b_valid",    32'(out_valid), 32'h1);
      chk("b2b_idx",      32'(out_idx),   32'(c % NFIELDS));
      chk("b2b_data",     32'(out_data),  32'(e));
      chk("b2b_in_ready", 32'(in_ready),  32'((c == NFIELDS - 1) || (c == 2 * NFIELDS - 1)));
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("b2b_idle_valid", 32'(out_valid), 32'h0);
    step();

    // 6: reset in the middle of a word at idx 10
    for (int i = 0; i < NFIELDS; i++) exp_q.push_back(ones_val(i));
    accept('1);
    drain(-1, 0, 10);
    exp_q.delete();
    #1;
    chk("mid_idx10", 32'(out_idx), 32'd10);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ready", 32'(in_ready),  32'h1);
    chk("mid_rst_idx",   32'(out_idx),   32'h0);
    chk("mid_rst_data",  32'(out_data),  32'h0);
    chk("mid_rst_last",  32'(out_last),  32'h0);
    chk("mid_rst_sig",   sig,            32'h0);
    rst_n = 1'b1;
    step();

    // word with only field 17 = 6'b000001 restarts at idx 0
    for (int i = 0; i < NFIELDS; i++) exp_q.push_back((i == 17) ? 8'h01 : 8'h00);
    accept(90'h1);
    drain(-1, 0, NFIELDS);
`ifdef VH_UNPACK_SIGNATURE_EN
    exp_sig = 32'h1;
`else
    exp_sig = 32'h0;
`endif
    #1;
    chk("sig_after_word", sig, exp_sig);
    chk("end_idle_valid", 32'(out_valid), 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
